// File: rtl/strobe_mon_pkg.sv
//------------------------------------------------------------------------------
// Module  : strobe_mon_pkg
// Brief   : Shared state encodings and width helper for the strobe monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package strobe_mon_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRAIN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Width able to hold 0..x-1, never narrower than one bit.
   function automatic int width_min1(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

`default_nettype wire

// File: rtl/strobe_monitor_if.sv
//------------------------------------------------------------------------------
// Module  : strobe_monitor_if
// Brief   : Strobe in / flywheel strobe, lock and error status out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface strobe_monitor_if #(
   parameter int NB_ERR = 16
);
   logic              i_valid;
   logic              o_valid;
   logic              o_locked;
   logic              o_err;
   logic [NB_ERR-1:0] o_err_count;

   modport master (
      output i_valid,
      input  o_valid, o_locked, o_err, o_err_count
   );

   modport slave (
      input  i_valid,
      output o_valid, o_locked, o_err, o_err_count
   );
endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module  : sat_counter
// Brief   : Up counter that sticks at all-ones.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
   parameter int NB = 16
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          i_inc,
   output logic [NB-1:0] o_count
);

   logic [NB-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/strobe_monitor.sv
//------------------------------------------------------------------------------
// Module  : strobe_monitor
// Brief   : Trains onto a periodic strobe, locks, regenerates a flywheel strobe
//           and flags missing/early strobes. STROBE_MON_ERRCNT_EN adds the
//           saturating error counter; otherwise o_err_count is tied to 0.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module strobe_monitor
   import strobe_mon_pkg::*;
#(
   parameter int N          = 4,
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 2,
   parameter int NB_ERR     = 16
) (
   input  logic             clk,
   input  logic             i_rst,
   strobe_monitor_if.slave  mon
);

   localparam int CNT_W  = width_min1(N);
   localparam int GOOD_W = width_min1(LOCK_CNT);
   localparam int BAD_W  = width_min1(UNLOCK_CNT);

   localparam logic [CNT_W-1:0]  c_last      = CNT_W'(N - 1);
   localparam logic [GOOD_W-1:0] c_good_last = GOOD_W'(LOCK_CNT - 1);
   localparam logic [BAD_W-1:0]  c_bad_last  = BAD_W'(UNLOCK_CNT - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [GOOD_W-1:0]  r_good;
   logic [BAD_W-1:0]   r_bad;
   logic               r_valid;
   logic               r_locked;
   logic               r_err;

   logic               w_slot;
   logic               w_good;
   logic               w_early;
   logic               w_miss;
   logic               w_err_evt;
   logic [CNT_W-1:0]   w_cnt_next;
   logic [NB_ERR-1:0]  w_err_count;

   assign w_slot     = (r_cnt == c_last);
   assign w_good     = mon.i_valid && w_slot;
   assign w_early    = mon.i_valid && !w_slot;
   assign w_miss     = !mon.i_valid && w_slot;
   assign w_err_evt  = (r_state == LOCKED) && (w_early || w_miss);
   assign w_cnt_next = w_slot ? '0 : r_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state  <= SEARCH;
         r_cnt    <= '0;
         r_good   <= '0;
         r_bad    <= '0;
         r_valid  <= 1'b0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            SEARCH: begin
               if (mon.i_valid) begin
                  r_cnt   <= '0;
                  r_good  <= '0;
                  r_state <= TRAIN;
               end
            end
            TRAIN: begin
               if (w_good) begin
                  r_cnt <= '0;
                  if (r_good == c_good_last) begin
                     r_good   <= '0;
                     r_bad    <= '0;
                     r_locked <= 1'b1;
                     r_state  <= LOCKED;
                  end else begin
                     r_good <= r_good + 1'b1;
                  end
               end else if (w_early) begin
                  r_cnt  <= '0;
                  r_good <= '0;
               end else if (w_miss) begin
                  r_good  <= '0;
                  r_state <= SEARCH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            LOCKED: begin
               // Flywheel: early strobes never realign, missing ones wrap anyway.
               r_valid <= w_slot;
               r_cnt   <= w_cnt_next;
               if (w_good) begin
                  r_bad <= '0;
               end else if (w_err_evt) begin
                  r_err <= 1'b1;
                  if (r_bad == c_bad_last) begin
                     r_bad    <= '0;
                     r_locked <= 1'b0;
                     r_state  <= SEARCH;
                  end else begin
                     r_bad <= r_bad + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= SEARCH;
            end
         endcase
      end
   end

`ifdef STROBE_MON_ERRCNT_EN
   sat_counter #(
      .NB (NB_ERR)
   ) u_err_count (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_inc   (w_err_evt),
      .o_count (w_err_count)
   );
`else
   assign w_err_count = '0;
`endif

   assign mon.o_valid     = r_valid;
   assign mon.o_locked    = r_locked;
   assign mon.o_err       = r_err;
   assign mon.o_err_count = w_err_count;

endmodule

`default_nettype wire

// File: tb/tb_strobe_monitor.sv
//------------------------------------------------------------------------------
// Module  : tb_strobe_monitor
// Brief   : Directed scenarios for strobe_monitor (N=4 main DUT, N=1 corner DUT).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_strobe_monitor;

`ifdef STROBE_MON_ERRCNT_EN
   localparam bit c_cnt_en = 1'b1;
`else
   localparam bit c_cnt_en = 1'b0;
`endif

   logic clk = 1'b0;
   logic i_rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   strobe_monitor_if #(.NB_ERR(16)) sif ();
   strobe_monitor_if #(.NB_ERR(2))  sif1 ();

   strobe_monitor #(
      .N(4), .LOCK_CNT(3), .UNLOCK_CNT(2), .NB_ERR(16)
   ) u_dut (
      .clk   (clk),
      .i_rst (i_rst),
      .mon   (sif)
   );

   strobe_monitor #(
      .N(1), .LOCK_CNT(1), .UNLOCK_CNT(16), .NB_ERR(2)
   ) u_dut1 (
      .clk   (clk),
      .i_rst (i_rst),
      .mon   (sif1)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic tick(input logic v, input logic v1, input logic r);
      sif.i_valid  = v;
      sif1.i_valid = v1;
      i_rst        = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b1);
      sif.i_valid  = 1'b0;
      sif1.i_valid = 1'b0;
      i_rst        = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (sif.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", sif.o_valid); end
      n_checks++; if (sif.o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", sif.o_locked); end
      n_checks++; if (sif.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", sif.o_err); end
      n_checks++; if (sif.o_err_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", sif.o_err_count); end
      n_checks++; if (sif1.o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked_n1 got %b exp 0", sif1.o_locked); end
   endtask

   task automatic test_lock();
      int c;
      logic e_v, e_l;
      do_reset();
      for (int t = 0; t <= 34; t++) begin
         tick((t >= 10) && ((t - 10) % 4 == 0), 1'b0, 1'b0);
         c   = t + 1;
         e_l = (c >= 23);
         e_v = (c >= 27) && ((c - 27) % 4 == 0);
         n_checks++; if (sif.o_locked !== e_l) begin n_fail++; $display("FAIL lock_locked c=%0d got %b exp %b", c, sif.o_locked, e_l); end
         n_checks++; if (sif.o_valid !== e_v) begin n_fail++; $display("FAIL lock_valid c=%0d got %b exp %b", c, sif.o_valid, e_v); end
         n_checks++; if (sif.o_err !== 1'b0) begin n_fail++; $display("FAIL lock_err c=%0d got %b exp 0", c, sif.o_err); end
      end
      n_checks++; if (sif.o_err_count !== 16'd0) begin n_fail++; $display("FAIL lock_count got %0d exp 0", sif.o_err_count); end
   endtask

   task automatic test_missing_one();
      int c;
      logic e_v, e_l, e_e;
      logic [15:0] e_c;
      do_reset();
      for (int t = 0; t <= 34; t++) begin
         tick((t >= 10) && ((t - 10) % 4 == 0) && (t != 26), 1'b0, 1'b0);
         c   = t + 1;
         e_l = (c >= 23);
         e_v = (c >= 27) && ((c - 27) % 4 == 0);
         e_e = (c == 27);
         e_c = (c_cnt_en && c >= 27) ? 16'd1 : 16'd0;
         n_checks++; if (sif.o_locked !== e_l) begin n_fail++; $display("FAIL miss1_locked c=%0d got %b exp %b", c, sif.o_locked, e_l); end
         n_checks++; if (sif.o_valid !== e_v) begin n_fail++; $display("FAIL miss1_valid c=%0d got %b exp %b", c, sif.o_valid, e_v); end
         n_checks++; if (sif.o_err !== e_e) begin n_fail++; $display("FAIL miss1_err c=%0d got %b exp %b", c, sif.o_err, e_e); end
         n_checks++; if (sif.o_err_count !== e_c) begin n_fail++; $display("FAIL miss1_count c=%0d got %0d exp %0d", c, sif.o_err_count, e_c); end
      end
   endtask

   task automatic test_missing_two();
      int c;
      logic e_v, e_l, e_e;
      logic [15:0] e_c;
      do_reset();
      for (int t = 0; t <= 36; t++) begin
         tick((t >= 10) && ((t - 10) % 4 == 0) && (t != 26) && (t != 30), 1'b0, 1'b0);
         c   = t + 1;
         e_l = (c >= 23) && (c < 31);
         e_v = (c == 27) || (c == 31);
         e_e = (c == 27) || (c == 31);
         e_c = !c_cnt_en ? 16'd0 : (c >= 31) ? 16'd2 : (c >= 27) ? 16'd1 : 16'd0;
         n_checks++; if (sif.o_locked !== e_l) begin n_fail++; $display("FAIL miss2_locked c=%0d got %b exp %b", c, sif.o_locked, e_l); end
         n_checks++; if (sif.o_valid !== e_v) begin n_fail++; $display("FAIL miss2_valid c=%0d got %b exp %b", c, sif.o_valid, e_v); end
         n_checks++; if (sif.o_err !== e_e) begin n_fail++; $display("FAIL miss2_err c=%0d got %b exp %b", c, sif.o_err, e_e); end
         n_checks++; if (sif.o_err_count !== e_c) begin n_fail++; $display("FAIL miss2_count c=%0d got %0d exp %0d", c, sif.o_err_count, e_c); end
      end
   endtask

   task automatic test_early();
      int c;
      logic e_v, e_l, e_e;
      logic [15:0] e_c;
      do_reset();
      for (int t = 0; t <= 34; t++) begin
         tick(((t >= 10) && ((t - 10) % 4 == 0)) || (t == 24), 1'b0, 1'b0);
         c   = t + 1;
         e_l = (c >= 23);
         e_v = (c >= 27) && ((c - 27) % 4 == 0);
         e_e = (c == 25);
         e_c = (c_cnt_en && c >= 25) ? 16'd1 : 16'd0;
         n_checks++; if (sif.o_locked !== e_l) begin n_fail++; $display("FAIL early_locked c=%0d got %b exp %b", c, sif.o_locked, e_l); end
         n_checks++; if (sif.o_valid !== e_v) begin n_fail++; $display("FAIL early_valid c=%0d got %b exp %b", c, sif.o_valid, e_v); end
         n_checks++; if (sif.o_err !== e_e) begin n_fail++; $display("FAIL early_err c=%0d got %b exp %b", c, sif.o_err, e_e); end
         n_checks++; if (sif.o_err_count !== e_c) begin n_fail++; $display("FAIL early_count c=%0d got %0d exp %0d", c, sif.o_err_count, e_c); end
      end
   endtask

   task automatic test_realign();
      int c;
      logic e_v, e_l;
      do_reset();
      for (int t = 0; t <= 37; t++) begin
         tick((t == 10) || (t == 14) || ((t >= 16) && ((t - 16) % 4 == 0)), 1'b0, 1'b0);
         c   = t + 1;
         e_l = (c >= 29);
         e_v = (c == 33) || (c == 37);
         n_checks++; if (sif.o_locked !== e_l) begin n_fail++; $display("FAIL realign_locked c=%0d got %b exp %b", c, sif.o_locked, e_l); end
         n_checks++; if (sif.o_valid !== e_v) begin n_fail++; $display("FAIL realign_valid c=%0d got %b exp %b", c, sif.o_valid, e_v); end
         n_checks++; if (sif.o_err !== 1'b0) begin n_fail++; $display("FAIL realign_err c=%0d got %b exp 0", c, sif.o_err); end
         n_checks++; if (sif.o_err_count !== 16'd0) begin n_fail++; $display("FAIL realign_count c=%0d got %0d exp 0", c, sif.o_err_count); end
      end
   endtask

   task automatic test_reset_mid();
      int c;
      logic e_v, e_l, e_e;
      logic [15:0] e_c;
      do_reset();
      for (int t = 0; t <= 56; t++) begin
         // Strobe 30 dropped to load the counter; strobe at 40 coincides with reset.
         tick(((t >= 10) && ((t - 10) % 4 == 0) && (t != 30)) || (t == 40), 1'b0, (t == 40));
         c   = t + 1;
         e_l = ((c >= 23) && (c <= 40)) || (c >= 55);
         e_v = (c == 27) || (c == 35) || (c == 39) || (c == 31);
         e_e = (c == 31);
         e_c = (c_cnt_en && c >= 31 && c <= 40) ? 16'd1 : 16'd0;
         n_checks++; if (sif.o_locked !== e_l) begin n_fail++; $display("FAIL rstmid_locked c=%0d got %b exp %b", c, sif.o_locked, e_l); end
         n_checks++; if (sif.o_valid !== e_v) begin n_fail++; $display("FAIL rstmid_valid c=%0d got %b exp %b", c, sif.o_valid, e_v); end
         n_checks++; if (sif.o_err !== e_e) begin n_fail++; $display("FAIL rstmid_err c=%0d got %b exp %b", c, sif.o_err, e_e); end
         n_checks++; if (sif.o_err_count !== e_c) begin n_fail++; $display("FAIL rstmid_count c=%0d got %0d exp %0d", c, sif.o_err_count, e_c); end
      end
   endtask

   task automatic test_n1_saturate();
      int c;
      logic e_v, e_l, e_e;
      logic [1:0] e_c;
      do_reset();
      for (int t = 0; t <= 23; t++) begin
         tick(1'b0, (t <= 3), 1'b0);
         c   = t + 1;
         e_l = (c >= 2) && (c < 20);
         e_v = (c >= 3) && (c <= 20);
         e_e = (c >= 5) && (c <= 20);
         e_c = !c_cnt_en ? 2'd0 : (c >= 7) ? 2'd3 : (c >= 5) ? 2'(c - 4) : 2'd0;
         n_checks++; if (sif1.o_locked !== e_l) begin n_fail++; $display("FAIL n1_locked c=%0d got %b exp %b", c, sif1.o_locked, e_l); end
         n_checks++; if (sif1.o_valid !== e_v) begin n_fail++; $display("FAIL n1_valid c=%0d got %b exp %b", c, sif1.o_valid, e_v); end
         n_checks++; if (sif1.o_err !== e_e) begin n_fail++; $display("FAIL n1_err c=%0d got %b exp %b", c, sif1.o_err, e_e); end
         n_checks++; if (sif1.o_err_count !== e_c) begin n_fail++; $display("FAIL n1_count c=%0d got %0d exp %0d", c, sif1.o_err_count, e_c); end
      end
   endtask

   initial begin
      sif.i_valid  = 1'b0;
      sif1.i_valid = 1'b0;
      i_rst        = 1'b1;
      test_reset();
      test_lock();
      test_missing_one();
      test_missing_two();
      test_early();
      test_realign();
      test_reset_mid();
      test_n1_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
